error_event_logger: RTL and testbench

Parametrised successor to the fixed 19-source error detector. Handles NUM_SRC generic error sources with per-source programmable severity and mask, and keeps sticky W1C status and saturating per-source counters. Unlike the fixed version, it queues every error event in a LOG_DEPTH FIFO with a valid/ready drain port, so simultaneous errors are never lost silently. Sits between the memory/compute/system error sources and the CSR/interrupt fabric.

---
 rtl/error_pkg.sv | 26 ++
 rtl/error_log_fifo.sv | 55 +++++
 rtl/error_event_logger.sv | 124 ++++++++++++
 tb/tb_error_event_logger.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/error_pkg.sv
// Shared types for the error event logger: severity encoding and log entry layout.
package error_pkg;

  localparam int unsigned SEV_W     = 3;
  localparam int unsigned SRC_IDX_W = 8;
  localparam int unsigned DEF_TS_W  = 32;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [SEV_W-1:0] {
    INFO     = 3'd0,
    WARNING  = 3'd1,
    MINOR    = 3'd2,
    MAJOR    = 3'd3,
    CRITICAL = 3'd4,
    FATAL    = 3'd5
  } severity_t;

  // Layout of one log word at the default timestamp/counter widths.
  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    severity_t            sev;
    logic [SRC_IDX_W-1:0] src;
    logic [DEF_CNT_W-1:0] cnt;
  } log_entry_t;

endpackage

// File: rtl/error_log_fifo.sv
// Synchronous FIFO with push/full on the write side and valid/ready on the read side.
module error_log_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;
  logic             do_push;

  assign pop_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign do_pop    = pop_valid & pop_ready;
  // A pop frees the slot in the same cycle, so a push while full still lands.
  assign do_push   = push & (~full | do_pop);
  assign rdata     = mem[rd_ptr];
  assign count     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/error_event_logger.sv
// Error event logger: edge detect, sticky status, saturating counters, and an
// arbitrated event log FIFO with drop counting and interrupt generation.
module error_event_logger
  import error_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 32,
  parameter int unsigned LOG_DEPTH = 16,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TS_W      = DEF_TS_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              err_in,
  input  logic [3*NUM_SRC-1:0]            sev_cfg,
  input  logic                            mask_wr,
  input  logic [NUM_SRC-1:0]              mask_wdata,
  input  logic [NUM_SRC-1:0]              status_clr,
  input  logic                            inject_valid,
  input  logic [$clog2(NUM_SRC)-1:0]      inject_src,
  input  logic [$clog2(LOG_DEPTH):0]      irq_threshold,
  output logic [NUM_SRC-1:0]              status,
  output logic [NUM_SRC-1:0]              mask,
  output logic [2:0]                      max_severity,
  output logic                            irq,
  output logic                            log_valid,
  input  logic                            log_ready,
  output logic [TS_W+3+8+CNT_W-1:0]       log_entry,
  output logic [$clog2(LOG_DEPTH):0]      log_count,
  output logic [CNT_W-1:0]                drop_count
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned EW    = TS_W + SEV_W + SRC_IDX_W + CNT_W;

  logic [NUM_SRC-1:0] err_q;
  logic [NUM_SRC-1:0] inj_vec;
  logic [NUM_SRC-1:0] ev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] grant_vec;
  logic [CNT_W-1:0]   cnt [NUM_SRC];
  logic [TS_W-1:0]    ts;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               fifo_full;
  logic               drop;
  logic [EW-1:0]      entry;

  // Rising edges plus one-hot decoded injection.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      inj_vec[i] = inject_valid && (inject_src == SRC_W'(i));
    end
    ev = (err_in & ~err_q) | inj_vec;
  end

  // Lowest-index pending source wins the enqueue slot.
  always_comb begin
    grant_any = |pending;
    grant_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = SRC_W'(i);
    end
    grant_vec = grant_any ? (NUM_SRC'(1) << grant_idx) : '0;
    entry     = {ts, sev_cfg[3*grant_idx +: 3], SRC_IDX_W'(grant_idx), cnt[grant_idx]};
  end

  assign drop = grant_any & fifo_full & ~(log_valid & log_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      ts         <= '0;
      pending    <= '0;
      status     <= '0;
      mask       <= '1;
      drop_count <= '0;
      irq        <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      err_q   <= err_in;
      ts      <= ts + TS_W'(1);
      pending <= (pending & ~grant_vec) | ev;
      if (mask_wr) mask <= mask_wdata;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
      irq <= (|(status & ~mask)) |
             ((irq_threshold != '0) && (log_count >= irq_threshold));
      // A new event beats a same-cycle clear and restarts the count at one.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (ev[i]) begin
          status[i] <= 1'b1;
          if (status_clr[i])     cnt[i] <= CNT_W'(1);
          else if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (status_clr[i]) begin
          status[i] <= 1'b0;
          cnt[i]    <= '0;
        end
      end
    end
  end

  always_comb begin
    max_severity = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (status[i] && !mask[i] && (sev_cfg[3*i +: 3] > max_severity))
        max_severity = sev_cfg[3*i +: 3];
    end
  end

  error_log_fifo #(
    .WIDTH (EW),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_any),
    .wdata     (entry),
    .full      (fifo_full),
    .pop_valid (log_valid),
    .pop_ready (log_ready),
    .rdata     (log_entry),
    .count     (log_count)
  );

endmodule

// File: tb/tb_error_event_logger.sv
// Self-checking bench for error_event_logger: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_error_event_logger;
  import error_pkg::*;

  localparam int unsigned NUM_SRC   = 32;
  localparam int unsigned LOG_DEPTH = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TS_W      = 32;
  localparam int unsigned EW        = TS_W + 3 + 8 + CNT_W;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_SRC-1:0]   err_in = '0;
  logic [3*NUM_SRC-1:0] sev_cfg = '0;
  logic                 mask_wr = 1'b0;
  logic [NUM_SRC-1:0]   mask_wdata = '0;
  logic [NUM_SRC-1:0]   status_clr = '0;
  logic                 inject_valid = 1'b0;
  logic [4:0]           inject_src = '0;
  logic [4:0]           irq_threshold = '0;
  logic [NUM_SRC-1:0]   status;
  logic [NUM_SRC-1:0]   mask;
  logic [2:0]           max_severity;
  logic                 irq;
  logic                 log_valid;
  logic                 log_ready = 1'b0;
  logic [EW-1:0]        log_entry;
  logic [4:0]           log_count;
  logic [CNT_W-1:0]     drop_count;

  error_event_logger #(
    .NUM_SRC(NUM_SRC), .LOG_DEPTH(LOG_DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .err_in(err_in), .sev_cfg(sev_cfg),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata), .status_clr(status_clr),
    .inject_valid(inject_valid), .inject_src(inject_src),
    .irq_threshold(irq_threshold), .status(status), .mask(mask),
    .max_severity(max_severity), .irq(irq), .log_valid(log_valid),
    .log_ready(log_ready), .log_entry(log_entry), .log_count(log_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [NUM_SRC-1:0] m_err_q, m_status, m_mask, m_pend;
  int unsigned        m_cnt [NUM_SRC];
  logic [EW-1:0]      m_q [$];
  int unsigned        m_drop;
  logic [TS_W-1:0]    m_ts;
  logic               m_irq;

  function automatic logic [2:0] sev_of(input int i);
    return 3'((i + 2) % 6);
  endfunction

  function automatic logic [2:0] m_maxsev();
    logic [2:0] r = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (m_status[i] && !m_mask[i] && sev_of(i) > r) r = sev_of(i);
    return r;
  endfunction

  task automatic model_reset();
    m_err_q = '0; m_status = '0; m_mask = '1; m_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = 0;
    m_q.delete();
    m_drop = 0; m_ts = '0; m_irq = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [NUM_SRC-1:0] ev;
    int g;
    int unsigned sz;
    bit pop;
    ev = err_in & ~m_err_q;
    if (inject_valid && int'(inject_src) < NUM_SRC) ev[inject_src] = 1'b1;
    g = -1;
    for (int i = 0; i < NUM_SRC; i++) if (m_pend[i] && g < 0) g = i;
    sz = m_q.size();
    m_irq = ((m_status & ~m_mask) != '0) || (irq_threshold != 0 && sz >= irq_threshold);
    pop = (sz > 0) && log_ready;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      if (sz < LOG_DEPTH || pop) m_q.push_back({m_ts, sev_of(g), 8'(g), 16'(m_cnt[g])});
      else if (m_drop < CNT_MAX) m_drop++;
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ev[i]) begin
        m_status[i] = 1'b1;
        if (status_clr[i]) m_cnt[i] = 1;
        else if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
      end else if (status_clr[i]) begin
        m_status[i] = 1'b0;
        m_cnt[i] = 0;
      end
    end
    m_pend |= ev;
    if (mask_wr) m_mask = mask_wdata;
    m_err_q = err_in;
    m_ts++;
  endtask

  task automatic compare_all();
    check("status", 64'(status), 64'(m_status));
    check("mask", 64'(mask), 64'(m_mask));
    check("max_severity", 64'(max_severity), 64'(m_maxsev()));
    check("irq", 64'(irq), 64'(m_irq));
    check("log_valid", 64'(log_valid), 64'(m_q.size() > 0));
    check("log_count", 64'(log_count), 64'(m_q.size()));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    if (m_q.size() > 0) check("log_entry", 64'(log_entry), 64'(m_q[0]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [NUM_SRC-1:0] e, input logic iv, input int is,
                        input logic [NUM_SRC-1:0] clr, input logic rdy);
    err_in = e; inject_valid = iv; inject_src = 5'(is); status_clr = clr;
    log_ready = rdy; mask_wr = 1'b0;
  endtask

  task automatic do_reset();
    set_in('0, 1'b0, 0, '0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_log_valid", 64'(log_valid), 64'(0));
    check("rst_log_count", 64'(log_count), 64'(0));
    check("rst_mask", 64'(mask), 64'({NUM_SRC{1'b1}}));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_status", 64'(status), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NUM_SRC-1:0] err;
    logic [NUM_SRC-1:0] clr;
    logic               mwr;
    logic [NUM_SRC-1:0] mdata;
    logic               rdy;
    logic [NUM_SRC-1:0] e_status;
    logic               e_irq;
    logic               e_valid;
    int                 e_count;
    logic [2:0]         e_maxsev;
    logic               chk_entry;
    logic [7:0]         e_src;
    logic [2:0]         e_sev;
    logic [15:0]        e_cnt;
  } vec_t;

  vec_t       tbl [6];
  log_entry_t le;
  int         n5;
  int         c5;

  initial begin
    for (int i = 0; i < NUM_SRC; i++) sev_cfg[3*i +: 3] = sev_of(i);
    #1;
    do_reset();

    // Single FATAL edge on source 3 with mask cleared
    tbl[0] = '{'0,    '0,    1'b1, '0, 1'b0, '0,    1'b0, 1'b0, 0, 3'd0, 1'b0, 8'd0, 3'd0, 16'd0};
    tbl[1] = '{32'h8, '0,    1'b0, '0, 1'b0, 32'h8, 1'b0, 1'b0, 0, 3'd5, 1'b0, 8'd0, 3'd0, 16'd0};
    tbl[2] = '{32'h8, '0,    1'b0, '0, 1'b0, 32'h8, 1'b1, 1'b1, 1, 3'd5, 1'b1, 8'd3, 3'd5, 16'd1};
    tbl[3] = '{32'h8, '0,    1'b0, '0, 1'b1, 32'h8, 1'b1, 1'b0, 0, 3'd5, 1'b0, 8'd0, 3'd0, 16'd0};
    tbl[4] = '{'0,    32'h8, 1'b0, '0, 1'b1, '0,    1'b1, 1'b0, 0, 3'd0, 1'b0, 8'd0, 3'd0, 16'd0};
    tbl[5] = '{'0,    '0,    1'b0, '0, 1'b1, '0,    1'b0, 1'b0, 0, 3'd0, 1'b0, 8'd0, 3'd0, 16'd0};
    for (int k = 0; k < 6; k++) begin
      set_in(tbl[k].err, 1'b0, 0, tbl[k].clr, tbl[k].rdy);
      mask_wr = tbl[k].mwr; mask_wdata = tbl[k].mdata;
      cycle();
      check($sformatf("tbl%0d_status", k), 64'(status), 64'(tbl[k].e_status));
      check($sformatf("tbl%0d_irq", k), 64'(irq), 64'(tbl[k].e_irq));
      check($sformatf("tbl%0d_valid", k), 64'(log_valid), 64'(tbl[k].e_valid));
      check($sformatf("tbl%0d_count", k), 64'(log_count), 64'(tbl[k].e_count));
      check($sformatf("tbl%0d_maxsev", k), 64'(max_severity), 64'(tbl[k].e_maxsev));
      if (tbl[k].chk_entry) begin
        le = log_entry_t'(log_entry);
        check($sformatf("tbl%0d_src", k), 64'(le.src), 64'(tbl[k].e_src));
        check($sformatf("tbl%0d_sev", k), 64'(le.sev), 64'(tbl[k].e_sev));
        check($sformatf("tbl%0d_cnt", k), 64'(le.cnt), 64'(tbl[k].e_cnt));
      end
    end

    // Simultaneous rises on 2 and 7 drain in index order
    set_in(32'h84, 1'b0, 0, '0, 1'b0);
    repeat (3) cycle();
    le = log_entry_t'(log_entry);
    check("pair_count", 64'(log_count), 64'(2));
    check("pair_first", 64'(le.src), 64'(2));
    log_ready = 1'b1;
    cycle();
    le = log_entry_t'(log_entry);
    check("pair_second", 64'(le.src), 64'(7));
    cycle();
    check("pair_empty", 64'(log_valid), 64'(0));

    // Held level on 5 yields a single event
    set_in(32'h20, 1'b0, 0, '0, 1'b1);
    n5 = 0; c5 = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      le = log_entry_t'(log_entry);
      if (log_valid && le.src == 8'd5) begin n5++; c5 = int'(le.cnt); end
    end
    check("held_entries", 64'(n5), 64'(1));
    check("held_cnt", 64'(c5), 64'(1));
    set_in('0, 1'b0, 0, '0, 1'b1); cycle();
    set_in('0, 1'b0, 0, 32'h20, 1'b1); cycle();

    // Three rises on 5 while lower sources keep it waiting coalesce into one entry
    set_in(32'h3E, 1'b1, 0, '0, 1'b0); cycle();
    set_in(32'h1E, 1'b0, 0, '0, 1'b0); cycle();
    set_in(32'h3E, 1'b0, 0, '0, 1'b0); cycle();
    set_in(32'h1E, 1'b0, 0, '0, 1'b0); cycle();
    set_in(32'h3E, 1'b0, 0, '0, 1'b0); cycle();
    set_in(32'h1E, 1'b0, 0, '0, 1'b0); cycle();
    set_in('0, 1'b0, 0, '0, 1'b1);
    n5 = 0; c5 = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      le = log_entry_t'(log_entry);
      if (log_valid && le.src == 8'd5) begin n5++; c5 = int'(le.cnt); end
    end
    check("coal_entries", 64'(n5), 64'(1));
    check("coal_cnt", 64'(c5), 64'(3));

    // Clear and injection on 4 in the same cycle: set wins
    set_in('0, 1'b1, 4, 32'h10, 1'b1); cycle();
    check("clrinj_status", 64'(status[4]), 64'(1));
    set_in('0, 1'b0, 0, '0, 1'b1); cycle();
    le = log_entry_t'(log_entry);
    check("clrinj_src", 64'(le.src), 64'(4));
    check("clrinj_cnt", 64'(le.cnt), 64'(1));
    repeat (2) cycle();
    set_in('0, 1'b0, 0, 32'h10, 1'b1); cycle();
    check("clr_status", 64'(status[4]), 64'(0));

    // Overflow: 20 injections with no drain
    do_reset();
    irq_threshold = 5'd8;
    for (int k = 0; k < 20; k++) begin
      set_in('0, 1'b1, k, '0, 1'b0); cycle();
    end
    set_in('0, 1'b0, 0, '0, 1'b0);
    repeat (3) cycle();
    check("ovf_count", 64'(log_count), 64'(16));
    check("ovf_drop", 64'(drop_count), 64'(4));
    check("ovf_irq", 64'(irq), 64'(1));

    // Reset with five entries queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in('0, 1'b1, k, '0, 1'b0); cycle();
    end
    set_in('0, 1'b0, 0, '0, 1'b0);
    repeat (2) cycle();
    check("pre_rst_count", 64'(log_count), 64'(5));
    do_reset();
    cycle();
    check("post_rst_irq", 64'(irq), 64'(0));

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) do_reset();
      err_in       = err_in ^ ($urandom & $urandom & $urandom & $urandom);
      inject_valid = ($urandom_range(0, 3) == 0);
      inject_src   = 5'($urandom_range(0, NUM_SRC - 1));
      status_clr   = ($urandom_range(0, 7) == 0) ? ($urandom & $urandom & $urandom) : '0;
      mask_wr      = ($urandom_range(0, 19) == 0);
      mask_wdata   = $urandom;
      log_ready    = (k < 2000) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) irq_threshold = 5'($urandom_range(0, 16));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
